reg_wb_scheduler: RTL and testbench
===================================

// Module: reg_wb_scheduler
// PURPOSE
//  Write-back scheduler and scoreboard for the 16x16 register group.
//  It shares the single register-file write port (regwr/w_addr/result) between
//  two producers, the ALU and the load unit, using round-robin arbitration.
//  It tracks pending destination writes per register and raises a hazard that
//  stalls the decoder. It sits between the execute/memory stages and the register group.
// PARAMETERS
//  DW      16  data width of the write port
//  AW      4   register address width (2**AW registers)
//  PEND_W  2   width of each per-register pending-write counter (max 2**PEND_W-1 outstanding)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  alu_valid  in   1   ALU has a result to write back
//  alu_addr   in   AW  ALU destination register
//  alu_data   in   DW  ALU result
//  alu_ready  out  1   ALU transfer accepted this cycle
//  ld_valid   in   1   load unit has data to write back
//  ld_addr    in   AW  load destination register
//  ld_data    in   DW  load data
//  ld_ready   out  1   load transfer accepted this cycle
//  iss_valid  in   1   decoder presents an instruction for issue
//  iss_dst    in   AW  destination of the issuing instruction
//  iss_src_a  in   AW  source A (always checked)
//  iss_src_b  in   AW  source B
//  iss_use_b  in   1   1 = source B is a register (0 = immediate, not checked)
//  hazard     out  1   issue blocked; the decoder must hold its inputs
//  regwr      out  1   register group write enable
//  w_addr     out  AW  register group write address
//  result     out  DW  register group write data
//  sb_err     out  1   sticky: commit to a register with zero pending count
// BEHAVIOUR
//  Reset: regwr=0, w_addr=0, result=0, sb_err=0, all counters=0, rr pointer=ALU; readys=0.
//  Arbitration is combinational from the valids and the rr pointer:
//   - Only one valid: that requester's ready=1.
//   - Both valid: the requester named by the rr pointer wins. The pointer then flips to the other requester.
//   - At most one ready is high per cycle. ready is never high without its valid.
//  Transfer = valid & ready. The accepted addr/data are registered, so regwr=1 with
//   w_addr/result on the next cycle (latency 1). With no transfer, regwr=0 the next cycle.
//   Back-to-back transfers give regwr high on consecutive cycles.
//  Scoreboard: cnt[r] is PEND_W bits wide. busy[r] = (cnt[r]!=0).
//  hazard = iss_valid & (busy[src_a] | (iss_use_b & busy[src_b]) | cnt[dst]==max).
//   It is combinational from registered counts; a commit does not bypass in the same cycle.
//  Issue fires when iss_valid & !hazard, and cnt[iss_dst] increments at the clock edge.
//  Commit fires on any cycle with regwr=1, and cnt[w_addr] decrements at that edge.
//   busy clears the cycle after the write lands.
//  Issue and commit to the same register in the same cycle leave the count unchanged.
//  Commit with cnt=0: the count stays 0 (no wrap) and sb_err is set until reset.
//  A requester is not blocked by the scoreboard; producers are trusted to be issued.
//  Reset asserted mid-operation clears all state immediately. Pending accepted writes are dropped.
// CONFIGURATION
//  REG0_WIRED_EN defined:
//   - A transfer with addr 0 is accepted (ready as normal) but produces regwr=0.
//   - An issue to dst 0 does not increment the counter.
//   - Source 0 is never busy.
//  REG0_WIRED_EN undefined: register 0 is an ordinary register, handled like all others.
// TESTING
//  1. Reset with alu_valid=1: while rst_n=0, alu_ready=0 and regwr=0.
//     After release, alu_addr=3/data=16'h1234 -> next cycle regwr=1, w_addr=3, result=16'h1234.
//  2. Both valid for 4 cycles (alu addr 1, ld addr 2): grants alternate ALU,LD,ALU,LD.
//     regwr stays high for 4 cycles with w_addr 1,2,1,2.
//  3. Issue dst=5; the next cycle issue src_a=5 -> hazard=1.
//     ALU commits r5 -> hazard=0 the cycle after regwr.
//  4. PEND_W=2: three issues to dst=7 are accepted; the fourth has hazard=1.
//     One commit to r7 -> the fourth issues the next cycle.
//  5. Same-cycle issue dst=4 and commit w_addr=4 with cnt[4]=1 -> cnt[4] stays 1, busy stays 1.
//  6. Commit to r9 with cnt[9]=0 -> sb_err=1 and stays 1. REG0_WIRED_EN: ALU addr 0 -> regwr stays 0.

Source files
------------

// File: rtl/reg_wb_scheduler_if.sv
// reg_wb_scheduler_if: producer, issue and register-group write-port signals of the write-back scheduler.
interface reg_wb_scheduler_if #(parameter int DW = 16, parameter int AW = 4);
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          iss_valid;
    logic [AW-1:0] iss_dst;
    logic [AW-1:0] iss_src_a;
    logic [AW-1:0] iss_src_b;
    logic          iss_use_b;
    logic          hazard;
    logic          regwr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] result;
    logic          sb_err;
    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               iss_valid, iss_dst, iss_src_a, iss_src_b, iss_use_b,
        input  alu_ready, ld_ready, hazard, regwr, w_addr, result, sb_err
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
               iss_valid, iss_dst, iss_src_a, iss_src_b, iss_use_b,
        output alu_ready, ld_ready, hazard, regwr, w_addr, result, sb_err
    );
endinterface

// File: rtl/reg_wb_scheduler.sv
// reg_wb_scheduler: round-robin ALU/load write-back arbiter with a pending-write scoreboard.
// Define REG0_WIRED_EN to treat register 0 as hard-wired (no writes, never pending).
module reg_wb_scheduler #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int PEND_W = 2
) (
    input logic          clk,
    input logic          rst_n,
    reg_wb_scheduler_if.slave bus
);
    localparam int NR = 1 << AW;
    localparam logic [PEND_W-1:0] CMAX = '1;
    logic                rr_q, rr_d;
    logic                regwr_q, regwr_d;
    logic [AW-1:0]       w_addr_q, w_addr_d;
    logic [DW-1:0]       result_q, result_d;
    logic                sb_err_q, sb_err_d;
    logic [PEND_W-1:0]   cnt_q [NR];
    logic [PEND_W-1:0]   cnt_d [NR];
    logic [NR-1:0]       busy;
    logic                alu_gnt, ld_gnt, hazard, issue;
    // rr_q=0 favours the ALU; readys are held low while reset is asserted
    always_comb begin
        alu_gnt  = rst_n & bus.alu_valid & (!bus.ld_valid | !rr_q);
        ld_gnt   = rst_n & bus.ld_valid & (!bus.alu_valid | rr_q);
        rr_d     = (bus.alu_valid & bus.ld_valid) ? ~rr_q : rr_q;
        w_addr_d = alu_gnt ? bus.alu_addr : ld_gnt ? bus.ld_addr : w_addr_q;
        result_d = alu_gnt ? bus.alu_data : ld_gnt ? bus.ld_data : result_q;
`ifdef REG0_WIRED_EN
        regwr_d  = (alu_gnt | ld_gnt) & (w_addr_d != '0);
`else
        regwr_d  = alu_gnt | ld_gnt;
`endif
    end
    always_comb begin
        for (int r = 0; r < NR; r++) busy[r] = cnt_q[r] != '0;
`ifdef REG0_WIRED_EN
        busy[0] = 1'b0;
`endif
        hazard = bus.iss_valid & (busy[bus.iss_src_a] | (bus.iss_use_b & busy[bus.iss_src_b]) |
                                  (cnt_q[bus.iss_dst] == CMAX));
`ifdef REG0_WIRED_EN
        issue  = bus.iss_valid & !hazard & (bus.iss_dst != '0);
`else
        issue  = bus.iss_valid & !hazard;
`endif
    end
    // simultaneous issue and commit to one register cancel; commits never wrap below zero
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            logic inc, dec;
            inc      = issue & (bus.iss_dst == AW'(r));
            dec      = regwr_q & (w_addr_q == AW'(r));
            cnt_d[r] = (inc & !dec) ? cnt_q[r] + 1'b1 :
                       (dec & !inc & (cnt_q[r] != '0)) ? cnt_q[r] - 1'b1 : cnt_q[r];
        end
        sb_err_d = sb_err_q | (regwr_q & (cnt_q[w_addr_q] == '0));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= 1'b0;
            regwr_q  <= 1'b0;
            w_addr_q <= '0;
            result_q <= '0;
            sb_err_q <= 1'b0;
            for (int r = 0; r < NR; r++) cnt_q[r] <= '0;
        end else begin
            rr_q     <= rr_d;
            regwr_q  <= regwr_d;
            w_addr_q <= w_addr_d;
            result_q <= result_d;
            sb_err_q <= sb_err_d;
            for (int r = 0; r < NR; r++) cnt_q[r] <= cnt_d[r];
        end
    end
    assign bus.alu_ready = alu_gnt;
    assign bus.ld_ready  = ld_gnt;
    assign bus.hazard    = hazard;
    assign bus.regwr     = regwr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.result    = result_q;
    assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb_reg_wb_scheduler: directed checks of arbitration, write-back latency and scoreboard hazards.
module tb_reg_wb_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    always #5 clk = ~clk;
    reg_wb_scheduler_if #(.DW(16), .AW(4)) bus ();
    reg_wb_scheduler #(.DW(16), .AW(4), .PEND_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic iss(input logic v, input logic [3:0] dst, input logic [3:0] a,
                       input logic [3:0] b, input logic ub);
        bus.iss_valid = v; bus.iss_dst = dst; bus.iss_src_a = a; bus.iss_src_b = b; bus.iss_use_b = ub;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 16'h1234;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        chk("rst_alu_ready", bus.alu_ready, 0);
        chk("rst_regwr", bus.regwr, 0);
        chk("rst_sb_err", bus.sb_err, 0);
        step();
        chk("rst_edge_regwr", bus.regwr, 0);
        chk("rst_edge_alu_ready", bus.alu_ready, 0);
        rst_n = 1'b1; #1;
        chk("t1_alu_ready", bus.alu_ready, 1);
        chk("t1_ld_ready", bus.ld_ready, 0);
        step();
        bus.alu_addr = 4'd1; bus.alu_data = 16'haaaa;
        bus.ld_valid = 1'b1; bus.ld_addr = 4'd2; bus.ld_data = 16'hbbbb; #1;
        chk("t1_regwr", bus.regwr, 1);
        chk("t1_w_addr", bus.w_addr, 3);
        chk("t1_result", bus.result, 16'h1234);
        chk("t2_g0_alu", bus.alu_ready, 1);
        chk("t2_g0_ld", bus.ld_ready, 0);
        step(); #1;
        chk("t2_w0_regwr", bus.regwr, 1);
        chk("t2_w0_addr", bus.w_addr, 1);
        chk("t2_w0_result", bus.result, 16'haaaa);
        chk("t2_g1_alu", bus.alu_ready, 0);
        chk("t2_g1_ld", bus.ld_ready, 1);
        step(); #1;
        chk("t2_w1_regwr", bus.regwr, 1);
        chk("t2_w1_addr", bus.w_addr, 2);
        chk("t2_w1_result", bus.result, 16'hbbbb);
        chk("t2_g2_alu", bus.alu_ready, 1);
        step(); #1;
        chk("t2_w2_addr", bus.w_addr, 1);
        chk("t2_g3_ld", bus.ld_ready, 1);
        chk("t2_g3_alu", bus.alu_ready, 0);
        step();
        bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; #1;
        chk("t2_w3_regwr", bus.regwr, 1);
        chk("t2_w3_addr", bus.w_addr, 2);
        chk("idle_alu_ready", bus.alu_ready, 0);
        chk("idle_ld_ready", bus.ld_ready, 0);
        step();
        iss(1'b1, 4'd0, 4'd1, 4'd0, 1'b0); #1;
        chk("idle_regwr", bus.regwr, 0);
        chk("zero_commit_sb_err", bus.sb_err, 1);
        chk("no_wrap_hazard", bus.hazard, 0);
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd6; bus.alu_data = 16'h6666;
        step(); #1;
        chk("pre_rst_regwr", bus.regwr, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_regwr", bus.regwr, 0);
        chk("mid_rst_w_addr", bus.w_addr, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_sb_err", bus.sb_err, 0);
        chk("mid_rst_alu_ready", bus.alu_ready, 0);
        bus.alu_valid = 1'b0;
        step();
        rst_n = 1'b1;
        iss(1'b1, 4'd5, 4'd0, 4'd0, 1'b0); #1;
        chk("t3_first_hazard", bus.hazard, 0);
        step();
        iss(1'b1, 4'd6, 4'd5, 4'd0, 1'b0); #1;
        chk("t3_src_a_hazard", bus.hazard, 1);
        iss(1'b1, 4'd6, 4'd0, 4'd5, 1'b1); #1;
        chk("t3_src_b_hazard", bus.hazard, 1);
        iss(1'b1, 4'd6, 4'd0, 4'd5, 1'b0); #1;
        chk("t3_imm_b_hazard", bus.hazard, 0);
        iss(1'b1, 4'd6, 4'd5, 4'd0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd5; bus.alu_data = 16'h5555;
        step();
        bus.alu_valid = 1'b0; #1;
        chk("t3_commit_regwr", bus.regwr, 1);
        chk("t3_commit_addr", bus.w_addr, 5);
        chk("t3_no_bypass", bus.hazard, 1);
        step(); #1;
        chk("t3_cleared", bus.hazard, 0);
        iss(1'b1, 4'd7, 4'd0, 4'd0, 1'b0); #1;
        chk("t4_iss1", bus.hazard, 0);
        step(); #1;
        chk("t4_iss2", bus.hazard, 0);
        step(); #1;
        chk("t4_iss3", bus.hazard, 0);
        step(); #1;
        chk("t4_iss4_full", bus.hazard, 1);
        step(); #1;
        chk("t4_still_full", bus.hazard, 1);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 16'h7777;
        step();
        bus.alu_valid = 1'b0; #1;
        chk("t4_commit_addr", bus.w_addr, 7);
        chk("t4_commit_hazard", bus.hazard, 1);
        step(); #1;
        chk("t4_after_commit", bus.hazard, 0);
        step(); #1;
        chk("t4_refull", bus.hazard, 1);
        iss(1'b0, 4'd7, 4'd0, 4'd0, 1'b0); #1;
        chk("t4_no_valid", bus.hazard, 0);
        chk("t4_sb_err", bus.sb_err, 0);
        iss(1'b1, 4'd4, 4'd0, 4'd0, 1'b0);
        step();
        iss(1'b0, 4'd4, 4'd0, 4'd0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd4; bus.alu_data = 16'h4444;
        step();
        bus.alu_valid = 1'b0;
        iss(1'b1, 4'd4, 4'd0, 4'd0, 1'b0); #1;
        chk("t5_regwr", bus.regwr, 1);
        chk("t5_w_addr", bus.w_addr, 4);
        chk("t5_issue_ok", bus.hazard, 0);
        step();
        iss(1'b1, 4'd0, 4'd4, 4'd0, 1'b0); #1;
        chk("t5_busy_kept", bus.hazard, 1);
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd4;
        step();
        bus.alu_valid = 1'b0;
        step();
        iss(1'b1, 4'd0, 4'd4, 4'd0, 1'b0); #1;
        chk("t5_drained", bus.hazard, 0);
        chk("t5_sb_err", bus.sb_err, 0);
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.ld_valid = 1'b1; bus.ld_addr = 4'd9; bus.ld_data = 16'h9999; #1;
        chk("t6_ld_ready", bus.ld_ready, 1);
        chk("t6_alu_ready", bus.alu_ready, 0);
        step();
        bus.ld_valid = 1'b0; #1;
        chk("t6_result", bus.result, 16'h9999);
        chk("t6_sb_err_pre", bus.sb_err, 0);
        step(); #1;
        chk("t6_sb_err_set", bus.sb_err, 1);
        step(); step();
        iss(1'b1, 4'd0, 4'd9, 4'd0, 1'b0); #1;
        chk("t6_sb_err_sticky", bus.sb_err, 1);
        chk("t6_no_wrap", bus.hazard, 0);
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd0; bus.alu_data = 16'h0f0f; #1;
        chk("r0_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0; #1;
`ifdef REG0_WIRED_EN
        chk("r0_regwr", bus.regwr, 0);
`else
        chk("r0_regwr", bus.regwr, 1);
`endif
        step();
        iss(1'b1, 4'd0, 4'd1, 4'd0, 1'b0);
        step();
        iss(1'b1, 4'd1, 4'd0, 4'd0, 1'b0); #1;
`ifdef REG0_WIRED_EN
        chk("r0_src_busy", bus.hazard, 0);
`else
        chk("r0_src_busy", bus.hazard, 1);
`endif
        iss(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
